// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Runs from CLOCK_50 with an internal pixel divider. Every output is a flop
// decoded from the *next* counter values, so the outputs always describe the
// pixel currently held in the counters.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FRAME_W  = 16,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int COL_W   = $clog2(H_TOTAL),
  localparam int ROW_W   = $clog2(V_TOTAL)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               enable,
  input  logic               restart,
  output logic               HS,
  output logic               VS,
  output logic               blank,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row,
  output logic               pix_en,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  generate
    if (CLK_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
      $error("vga_timing_gen: porch/sync widths must be >= 1 and CLK_DIV >= 1");
    end
  endgenerate

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COL_W-1:0] H_LAST   = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] H_ACT    = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] H_EOL    = COL_W'(H_ACTIVE - 1);
  localparam logic [COL_W-1:0] HS_BEG   = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] HS_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [ROW_W-1:0] V_LAST   = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_ACT    = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] VS_BEG   = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] VS_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [COL_W-1:0] r_h;
  logic [ROW_W-1:0] r_v;
  // Cleared by reset; the first enabled edge after reset only presents
  // pixel (0,0) without stepping, so pixel 0 gets a full pixel period.
  logic             r_run;

  logic [DIV_W-1:0] w_div_n;
  logic [COL_W-1:0] w_h_n;
  logic [ROW_W-1:0] w_v_n;
  logic             w_frame_inc;
  logic             w_pix_n;

  // Next counter state; restart overrides freeze and the natural wrap.
  always_comb begin
    w_div_n     = r_div;
    w_h_n       = r_h;
    w_v_n       = r_v;
    w_frame_inc = 1'b0;
    if (restart) begin
      w_div_n = '0;
      w_h_n   = '0;
      w_v_n   = '0;
    end else if (enable && r_run) begin
      if (r_div == DIV_LAST) begin
        w_div_n = '0;
        if (r_h == H_LAST) begin
          w_h_n = '0;
          if (r_v == V_LAST) begin
            w_v_n       = '0;
            w_frame_inc = 1'b1;
          end else begin
            w_v_n = r_v + 1'b1;
          end
        end else begin
          w_h_n = r_h + 1'b1;
        end
      end else begin
        w_div_n = r_div + 1'b1;
      end
    end
    w_pix_n = enable && (w_div_n == DIV_LAST);
  end

  // Counters and registered decode of the pixel being loaded into them.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_div     <= '0;
      r_h       <= '0;
      r_v       <= '0;
      r_run     <= 1'b0;
      frame_cnt <= '0;
      HS        <= ~HS_POL;
      VS        <= ~VS_POL;
      blank     <= 1'b1;
      col       <= '0;
      row       <= '0;
      pix_en    <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else if (restart || enable) begin
      r_div     <= w_div_n;
      r_h       <= w_h_n;
      r_v       <= w_v_n;
      r_run     <= 1'b1;
      frame_cnt <= frame_cnt + FRAME_W'(w_frame_inc);
      HS        <= (w_h_n >= HS_BEG && w_h_n < HS_END) ? HS_POL : ~HS_POL;
      VS        <= (w_v_n >= VS_BEG && w_v_n < VS_END) ? VS_POL : ~VS_POL;
      blank     <= (w_h_n >= H_ACT) || (w_v_n >= V_ACT);
      col       <= (w_h_n < H_ACT) ? w_h_n : '0;
      row       <= (w_v_n < V_ACT) ? w_v_n : '0;
      pix_en    <= w_pix_n;
      sof       <= w_pix_n && (w_h_n == '0) && (w_v_n == '0);
      eol       <= w_pix_n && (w_h_n == H_EOL) && (w_v_n < V_ACT);
    end else begin
      // Frozen: raster position and levels hold, strobes are suppressed.
      pix_en <= 1'b0;
      sof    <= 1'b0;
      eol    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line
// timing, freeze, restart and async reset, plus a tiny CLK_DIV=1 instance
// for whole-frame, frame-counter wrap and restart-vs-wrap behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Default-geometry instance
  logic        d_rst, d_en, d_rs;
  logic        d_hs, d_vs, d_blank, d_pix, d_sof, d_eol;
  logic [9:0]  d_col, d_row;
  logic [15:0] d_fc;

  // Small instance: H 8/1/2/1 (12), V 4/1/1/1 (7), positive syncs
  logic        s_rst, s_en, s_rs;
  logic        s_hs, s_vs, s_blank, s_pix, s_sof, s_eol;
  logic [3:0]  s_col;
  logic [2:0]  s_row;
  logic [1:0]  s_fc;

  vga_timing_gen u_def (
    .CLOCK_50(clk), .reset(d_rst), .enable(d_en), .restart(d_rs),
    .HS(d_hs), .VS(d_vs), .blank(d_blank), .col(d_col), .row(d_row),
    .pix_en(d_pix), .sof(d_sof), .eol(d_eol), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FRAME_W(2)
  ) u_small (
    .CLOCK_50(clk), .reset(s_rst), .enable(s_en), .restart(s_rs),
    .HS(s_hs), .VS(s_vs), .blank(s_blank), .col(s_col), .row(s_row),
    .pix_en(s_pix), .sof(s_sof), .eol(s_eol), .frame_cnt(s_fc)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int hs_low, first_fall, n_eol, eol_c, n_vis, max_col, n_sof, frz_bad;
  int h, v;

  initial begin
    d_rst = 1'b1; d_en = 1'b1; d_rs = 1'b0;
    s_rst = 1'b1; s_en = 1'b1; s_rs = 1'b0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    chk("rst_hs",    32'(d_hs), 1);
    chk("rst_vs",    32'(d_vs), 1);
    chk("rst_blank", 32'(d_blank), 1);
    chk("rst_col",   32'(d_col), 0);
    chk("rst_row",   32'(d_row), 0);
    chk("rst_pix",   32'(d_pix), 0);
    chk("rst_sof",   32'(d_sof), 0);
    chk("rst_eol",   32'(d_eol), 0);
    chk("rst_fc",    32'(d_fc), 0);
    chk("rst_s_hs",  32'(s_hs), 0);
    chk("rst_s_vs",  32'(s_vs), 0);

    // ---- first line after release; cycle c shows pixel (c-1)/2 ----
    d_rst = 1'b0;
    hs_low = 0; first_fall = 0; n_eol = 0; eol_c = 0; n_vis = 0; max_col = 0; n_sof = 0;
    for (int c = 1; c <= 1600; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("c1_blank", 32'(d_blank), 0);
        chk("c1_col",   32'(d_col), 0);
        chk("c1_pix",   32'(d_pix), 0);
        chk("c1_hs",    32'(d_hs), 1);
        chk("c1_vs",    32'(d_vs), 1);
      end
      if (c == 2) begin
        chk("c2_pix", 32'(d_pix), 1);
        chk("c2_sof", 32'(d_sof), 1);
      end
      if (c == 3) begin
        chk("c3_col", 32'(d_col), 1);
        chk("c3_pix", 32'(d_pix), 0);
      end
      if (!d_hs) begin
        hs_low++;
        if (first_fall == 0) first_fall = c;
      end
      if (d_eol) begin
        n_eol++;
        if (eol_c == 0) eol_c = c;
      end
      if (d_pix && !d_blank) n_vis++;
      if (int'(d_col) > max_col) max_col = int'(d_col);
      if (d_sof) n_sof++;
    end
    chk("hs_low_cycles", 32'(hs_low), 192);
    // start of col 0 is cycle 1; HS falls 1312 cycles later
    chk("hs_first_fall", 32'(first_fall), 1313);
    chk("eol_count",     32'(n_eol), 1);
    chk("eol_cycle",     32'(eol_c), 1280);
    chk("vis_pix_line",  32'(n_vis), 640);
    chk("max_col",       32'(max_col), 639);
    chk("sof_line",      32'(n_sof), 1);

    @(negedge clk);
    chk("line1_row", 32'(d_row), 1);
    chk("line1_col", 32'(d_col), 0);

    // ---- freeze mid-line at col 100 ----
    repeat (200) @(negedge clk);
    chk("frz_col_pre", 32'(d_col), 100);
    chk("frz_pix_pre", 32'(d_pix), 0);
    d_en = 1'b0;
    frz_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (d_pix || d_sof || d_eol || d_col != 10'd100 || d_hs != 1'b1) frz_bad++;
    end
    chk("frz_hold_bad", 32'(frz_bad), 0);
    chk("frz_col",      32'(d_col), 100);
    d_en = 1'b1;
    @(negedge clk);
    chk("resume_col", 32'(d_col), 100);
    chk("resume_pix", 32'(d_pix), 1);
    @(negedge clk);
    chk("resume_col2", 32'(d_col), 101);

    // ---- restart at row 5, col 300 ----
    repeat (6798) @(negedge clk);
    chk("rs_pre_row", 32'(d_row), 5);
    chk("rs_pre_col", 32'(d_col), 300);
    d_rs = 1'b1;
    @(negedge clk);
    d_rs = 1'b0;
    chk("rs_col",   32'(d_col), 0);
    chk("rs_row",   32'(d_row), 0);
    chk("rs_blank", 32'(d_blank), 0);
    chk("rs_pix",   32'(d_pix), 0);
    chk("rs_fc",    32'(d_fc), 0);
    @(negedge clk);
    chk("rs_sof", 32'(d_sof), 1);

    // ---- async reset at row 10, col 50 (no clock edge before checking) ----
    repeat (16099) @(negedge clk);
    chk("ar_pre_row",   32'(d_row), 10);
    chk("ar_pre_col",   32'(d_col), 50);
    chk("ar_pre_blank", 32'(d_blank), 0);
    d_rst = 1'b1;
    #1;
    chk("ar_row",   32'(d_row), 0);
    chk("ar_col",   32'(d_col), 0);
    chk("ar_blank", 32'(d_blank), 1);
    chk("ar_hs",    32'(d_hs), 1);

    // ---- small instance: 4 frames + 2 pixels against the raster model ----
    s_rst = 1'b0;
    for (int p = 0; p <= 337; p++) begin
      @(negedge clk);
      h = p % 12;
      v = (p / 12) % 7;
      chk("s_hs",    32'(s_hs),    32'(h == 9 || h == 10));
      chk("s_vs",    32'(s_vs),    32'(v == 5));
      chk("s_blank", 32'(s_blank), 32'(h >= 8 || v >= 4));
      chk("s_col",   32'(s_col),   (h < 8) ? h : 0);
      chk("s_row",   32'(s_row),   (v < 4) ? v : 0);
      chk("s_pix",   32'(s_pix),   1);
      chk("s_sof",   32'(s_sof),   32'(h == 0 && v == 0));
      chk("s_eol",   32'(s_eol),   32'(h == 7 && v < 4));
      chk("s_fc",    32'(s_fc),    (p / 84) % 4);
    end

    // frame 5 (frame_cnt 1), pixel 26 = (h2, v2)
    repeat (109) @(negedge clk);
    chk("s_mid_fc",  32'(s_fc), 1);
    chk("s_mid_col", 32'(s_col), 2);
    chk("s_mid_row", 32'(s_row), 2);
    // restart wins over enable=0
    s_rs = 1'b1; s_en = 1'b0;
    @(negedge clk);
    s_rs = 1'b0; s_en = 1'b1;
    chk("s_rs_col",   32'(s_col), 0);
    chk("s_rs_row",   32'(s_row), 0);
    chk("s_rs_blank", 32'(s_blank), 0);
    chk("s_rs_pix",   32'(s_pix), 0);
    chk("s_rs_fc",    32'(s_fc), 1);
    @(negedge clk);
    chk("s_rs_col1", 32'(s_col), 1);
    chk("s_rs_pix1", 32'(s_pix), 1);

    // restart coinciding with the natural end-of-frame wrap
    repeat (82) @(negedge clk);
    chk("s_last_blank", 32'(s_blank), 1);
    chk("s_last_hs",    32'(s_hs), 0);
    chk("s_last_vs",    32'(s_vs), 0);
    s_rs = 1'b1;
    @(negedge clk);
    s_rs = 1'b0;
    chk("s_wrap_rs_fc",  32'(s_fc), 1);
    chk("s_wrap_rs_sof", 32'(s_sof), 1);
    chk("s_wrap_rs_col", 32'(s_col), 0);

    // one full natural frame afterwards
    repeat (84) @(negedge clk);
    chk("s_nat_fc",  32'(s_fc), 2);
    chk("s_nat_sof", 32'(s_sof), 1);

    // freeze with CLK_DIV=1 suppresses the otherwise constant strobe
    s_en = 1'b0;
    @(negedge clk);
    chk("s_frz_pix", 32'(s_pix), 0);
    chk("s_frz_sof", 32'(s_sof), 0);
    chk("s_frz_col", 32'(s_col), 0);
    chk("s_frz_fc",  32'(s_fc), 2);
    s_en = 1'b1;
    @(negedge clk);
    chk("s_unfrz_col", 32'(s_col), 1);
    chk("s_unfrz_pix", 32'(s_pix), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
